// File: rtl/node_fifo.sv
// node_fifo: valid/ready FIFO placed between two pipeline nodes.
// Ports: clk, rst_n, data_in/up_valid_in/up_ready_out (upstream),
//   data_out/dn_valid_out/dn_ready_in (downstream), count_out (fill level).
module node_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       up_valid_in,
    output logic                       up_ready_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       dn_valid_out,
    input  logic                       dn_ready_in,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs come from cnt only, so neither ready nor
    // valid has a combinational path from the opposite side.
    assign up_ready_out = (cnt != CW'(DEPTH));
    assign dn_valid_out = (cnt != '0);
    assign count_out    = cnt;
    assign data_out     = mem[rd_ptr];

    assign in_fire  = up_valid_in & up_ready_out;
    assign out_fire = dn_valid_out & dn_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({in_fire, out_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_node_fifo.sv
// tb_node_fifo: directed scoreboard bench for node_fifo.
// Drives at negedge, checks against a queue model before each posedge.
module tb_node_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             up_valid_in = 1'b0;
    logic             up_ready_out;
    logic [WIDTH-1:0] data_out;
    logic             dn_valid_out;
    logic             dn_ready_in = 1'b0;
    logic [2:0]       count_out;

    node_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .up_valid_in  (up_valid_in),
        .up_ready_out (up_ready_out),
        .data_out     (data_out),
        .dn_valid_out (dn_valid_out),
        .dn_ready_in  (dn_ready_in),
        .count_out    (count_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [WIDTH-1:0] q [$];
    logic m_in;
    logic m_out;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"}, 64'(up_ready_out), 64'd1);
        chk({tag, "_vld"}, 64'(dn_valid_out), 64'd0);
        chk({tag, "_cnt"}, 64'(count_out), 64'd0);
        chk({tag, "_dat"}, 64'(data_out), 64'd0);
    endtask

    // One clock: check status against the model, then advance the model.
    task automatic cycle();
        #1;
        m_in  = up_valid_in && (q.size() < DEPTH);
        m_out = dn_ready_in && (q.size() > 0);
        chk("count", 64'(count_out), 64'(q.size()));
        chk("up_rdy", 64'(up_ready_out), 64'(q.size() != DEPTH));
        chk("dn_vld", 64'(dn_valid_out), 64'(q.size() != 0));
        chk("cnt_max", 64'(count_out <= 3'(DEPTH)), 64'd1);
        if (q.size() > 0) begin
            chk("head", 64'(data_out), 64'(q[0]));
        end
        @(posedge clk);
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(data_in);
        @(negedge clk);
    endtask

    initial begin
        int v;
        int guard;
        int rx;
        int cyc;

        // Reset held for 10 cycles
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 chk_reset_outputs("rst");
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1 chk_reset_outputs("rst_rel");

        // Streaming 0..15 with downstream always ready
        dn_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            up_valid_in = 1'b1;
            data_in     = WIDTH'(i);
            cycle();
            chk("stream_cnt", 64'(count_out), 64'd1);
            chk("stream_dat", 64'(data_out), 64'(i));
        end
        up_valid_in = 1'b0;
        cycle();
        chk("stream_empty", 64'(dn_valid_out), 64'd0);

        // Fill and stall with 16..19
        dn_ready_in = 1'b0;
        for (int i = 16; i < 20; i++) begin
            up_valid_in = 1'b1;
            data_in     = WIDTH'(i);
            cycle();
            chk("fill_cnt", 64'(count_out), 64'(i - 15));
        end
        chk("full_rdy", 64'(up_ready_out), 64'd0);
        data_in = 32'd20;
        cycle();
        cycle();
        chk("full_hold", 64'(count_out), 64'd4);

        // Pop while full: 16 leaves, 20 is not taken this cycle
        dn_ready_in = 1'b1;
        cycle();
        chk("pop_full_cnt", 64'(count_out), 64'd3);
        chk("pop_full_hd", 64'(data_out), 64'd17);
        dn_ready_in = 1'b0;
        cycle();
        chk("accept20", 64'(count_out), 64'd4);
        up_valid_in = 1'b0;
        dn_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("drained", 64'(count_out), 64'd0);

        // Random back-pressure, 17..32, valid gapped
        v     = 17;
        rx    = 0;
        guard = 0;
        cyc   = 0;
        while ((v <= 32 || q.size() != 0) && guard < 400) begin
            dn_ready_in = 1'($urandom_range(0, 1));
            if (!up_valid_in && (cyc % 2 == 0) && v <= 32) begin
                up_valid_in = 1'b1;
                data_in     = WIDTH'(v);
            end
            cycle();
            if (m_out) rx++;
            if (m_in) begin
                v++;
                up_valid_in = 1'b0;
            end
            cyc++;
            guard++;
        end
        up_valid_in = 1'b0;
        chk("rand_done", 64'(guard < 400), 64'd1);
        chk("rand_rx", 64'(rx), 64'd16);

        // Asynchronous reset mid-operation with three words queued
        dn_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up_valid_in = 1'b1;
            data_in     = WIDTH'(100 + i);
            cycle();
        end
        up_valid_in = 1'b0;
        chk("pre_rst_cnt", 64'(count_out), 64'd3);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst");
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        up_valid_in = 1'b1;
        data_in     = 32'd40;
        cycle();
        up_valid_in = 1'b0;
        chk("post40_dat", 64'(data_out), 64'd40);
        chk("post40_vld", 64'(dn_valid_out), 64'd1);
        dn_ready_in = 1'b1;
        cycle();
        cycle();
        chk("post40_empty", 64'(dn_valid_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/node_fifo.md
# node_fifo

Parameterised synchronous FIFO with valid/ready handshakes on both sides, placed between two pipeline nodes so a bursty producer can run ahead of a stalled consumer by up to DEPTH words. It uses the same upstream/downstream port set as the pipeline nodes and drops into a chain in place of, or between, any node. There is no combinational path from dn_ready_in to up_ready_out or from up_valid_in to dn_valid_out, so it also breaks both handshake timing paths.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 4, number of storage entries; must be a power of two and at least 2
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  upstream data word
- up_valid_in  input  1  upstream offers data_in this cycle
- up_ready_out  output  1  FIFO can accept a word this cycle
- data_out  output  WIDTH  head-of-queue word
- dn_valid_out  output  1  data_out holds a valid word
- dn_ready_in  input  1  downstream accepts data_out this cycle
- count_out  output  $clog2(DEPTH)+1  number of words currently stored

## Operation
- Storage: DEPTH x WIDTH array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter cnt. Both pointers and the counter are $clog2(DEPTH) bits except cnt, which is one bit wider. Pointers wrap modulo DEPTH naturally.
- in_fire = up_valid_in & up_ready_out. out_fire = dn_valid_out & dn_ready_in.
- up_ready_out = (cnt != DEPTH). dn_valid_out = (cnt != 0). count_out = cnt. All three are decoded from registered state only.
- data_out = mem[rd_ptr], which is a combinational read of the head entry.
- On in_fire: mem[wr_ptr] <= data_in, and wr_ptr increments.
- On out_fire: rd_ptr increments.
- Counter update: in_fire only gives cnt+1. out_fire only gives cnt-1. Both or neither leaves cnt unchanged.
- Full (cnt == DEPTH): up_ready_out is low, so no write occurs even if dn_ready_in is high the same cycle. A full FIFO accepts again one cycle after a pop.
- Empty (cnt == 0): dn_valid_out is low. A word written this cycle is not visible until the next cycle, so there is no bypass.
- Simultaneous push and pop with 0 < cnt < DEPTH: both happen, cnt holds, and ordering is preserved.
- Behaviour is strictly first-in, first-out. No word is dropped or duplicated under any valid/ready pattern.
- Reset (asynchronous, any time, including mid-burst): wr_ptr, rd_ptr and cnt go to 0, and all mem entries go to 0. Outputs under reset are up_ready_out=1, dn_valid_out=0, count_out=0, data_out=0. Contents in flight are discarded.

## Timing
- Latency from an accepted input word to its appearance on data_out with dn_valid_out=1 is 1 cycle when the FIFO is empty. Otherwise it is 1 cycle plus the words ahead of it.
- Throughput is 1 word per cycle sustained when both sides are ready and 0 < cnt < DEPTH.
- up_ready_out and dn_valid_out change only after a rising clk edge or on rst_n assertion.
- Upstream must hold data_in and up_valid_in stable until in_fire. The FIFO holds data_out and dn_valid_out stable until out_fire.
- On rst_n release, the first write can be accepted at the first rising edge where rst_n is high.

## Test plan
- Reset check: hold rst_n=0 for 10 cycles, then release -> up_ready_out=1, dn_valid_out=0, count_out=0, data_out=0 throughout reset and on the first cycle after release.
- Streaming: with WIDTH=32 and DEPTH=4, dn_ready_in=1, push 0..15 back-to-back -> data_out shows 0..15 in order, each one cycle after acceptance; count_out stays 1; no stall cycles.
- Fill and stall: dn_ready_in=0, push 16,17,18,19 -> count_out steps 1,2,3,4 and up_ready_out falls after the 4th write. Pushing 20 is refused (in_fire=0) while full.
- Full with simultaneous pop: with the FIFO full and 20 held on data_in, raise dn_ready_in for 1 cycle -> 16 is popped and 20 is not written that cycle. The next cycle up_ready_out=1 and 20 is accepted; drained order is 17,18,19,20.
- Random back-pressure: send 17..32 with up_valid_in gapped every other cycle and dn_ready_in toggled pseudo-randomly -> received sequence is exactly 17..32, count_out never exceeds 4, and no word is duplicated.
- Reset mid-operation: assert rst_n with count_out=3 -> dn_valid_out=0 and count_out=0 immediately (asynchronously). After release, pushing 40 yields data_out=40 one cycle later with none of the old data seen.
